// File: rtl/cond_select_pipe.sv
// Multi-lane conditional select (b = sel ? c : d, or b = e when bypassed)
// feeding a STAGES-deep valid/ready register pipeline with a transfer counter.
module cond_select_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int MODE     = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] c_data,
  input  logic [CHANNELS*WIDTH-1:0] d_data,
  input  logic [CHANNELS*WIDTH-1:0] e_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]          xfer_count
);

  localparam int DW = CHANNELS * WIDTH;

  logic              bypass;
  logic [DW-1:0]     result;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic [DW-1:0]     data_q [STAGES];
  logic              xfer;

  always_comb begin
    bypass = (MODE == 1) || ((MODE == 2) && mode_i);
    result = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bypass)
        result[i*WIDTH +: WIDTH] = e_data[i*WIDTH +: WIDTH];
      else if (sel[i])
        result[i*WIDTH +: WIDTH] = c_data[i*WIDTH +: WIDTH];
      else
        result[i*WIDTH +: WIDTH] = d_data[i*WIDTH +: WIDTH];
    end
  end

  // The recursive "empty or downstream advancing" chain flattens to: some
  // stage at or after k is empty, or the consumer is taking the head beat.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = out_ready || !(&valid_q[STAGES-1:k]);
  end

  assign xfer      = valid_q[STAGES-1] && out_ready;
  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      xfer_count <= '0;
      for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) data_q[0] <= result;
      end
      // Data only moves with a valid beat so an emptied output holds its last value.
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
      if (xfer) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_select_pipe.sv
// Bench for cond_select_pipe: three parameterisations share one stimulus bus and
// one queue-based reference model; directed literal cases plus random traffic.
module tb_cond_select_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode_i, iv, orr;
  logic [3:0]  sel_v;
  logic [31:0] c_v, d_v, e_v;
  int          dsel;

  logic        iv_a, or_a, ir_a, ov_a;
  logic [31:0] od_a;
  logic [15:0] xc_a;
  logic        iv_b, or_b, ir_b, ov_b;
  logic [31:0] od_b;
  logic [3:0]  xc_b;
  logic        iv_c, or_c, ir_c, ov_c;
  logic [7:0]  od_c;
  logic [15:0] xc_c;

  logic        ir, ov;
  logic [31:0] od;
  logic [15:0] xc;

  cond_select_pipe #(.WIDTH(8), .CHANNELS(4), .STAGES(2), .MODE(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid(iv_a), .in_ready(ir_a),
    .sel(sel_v), .c_data(c_v), .d_data(d_v), .e_data(e_v),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .xfer_count(xc_a));

  cond_select_pipe #(.WIDTH(8), .CHANNELS(4), .STAGES(2), .MODE(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid(iv_b), .in_ready(ir_b),
    .sel(sel_v), .c_data(c_v), .d_data(d_v), .e_data(e_v),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .xfer_count(xc_b));

  cond_select_pipe #(.WIDTH(8), .CHANNELS(1), .STAGES(1), .MODE(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid(iv_c), .in_ready(ir_c),
    .sel(sel_v[0:0]), .c_data(c_v[7:0]), .d_data(d_v[7:0]), .e_data(e_v[7:0]),
    .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .xfer_count(xc_c));

  // Only the selected DUT sees traffic; the others idle with out_ready high.
  always_comb begin
    iv_a = iv && (dsel == 0);
    iv_b = iv && (dsel == 1);
    iv_c = iv && (dsel == 2);
    or_a = (dsel == 0) ? orr : 1'b1;
    or_b = (dsel == 1) ? orr : 1'b1;
    or_c = (dsel == 2) ? orr : 1'b1;
    case (dsel)
      0:       begin ir = ir_a; ov = ov_a; od = od_a;           xc = xc_a;           end
      1:       begin ir = ir_b; ov = ov_b; od = od_b;           xc = {12'b0, xc_b};  end
      default: begin ir = ir_c; ov = ov_c; od = {24'b0, od_c};  xc = xc_c;           end
    endcase
  end

  // Reference model: FIFO of accepted beats tagged with their accept edge.
  // A beat is visible at the output once it is the oldest and has been
  // inside the pipe for at least STAGES-1 further edges; the pipe is full
  // exactly when it holds STAGES beats.
  typedef struct {
    logic [31:0] data;
    int          acc;
  } ent_t;
  ent_t q[$];
  int   ecnt, mcount;
  bit   armed;
  int   total, bad;

  logic        s_ir, s_ov;
  logic [31:0] s_od;
  logic [15:0] s_xc;

  function automatic int stages_of(int d);  return (d == 2) ? 1 : 2; endfunction
  function automatic int lanes_of(int d);   return (d == 2) ? 1 : 4; endfunction
  function automatic int mode_of(int d);    return (d == 0) ? 2 : ((d == 1) ? 0 : 1); endfunction
  function automatic int cmask_of(int d);   return (d == 1) ? 32'hF : 32'hFFFF; endfunction

  function automatic logic [31:0] model_res(int d, logic mi, logic [3:0] s,
                                            logic [31:0] c, logic [31:0] dd, logic [31:0] e);
    logic [31:0] r;
    bit byp;
    r   = '0;
    byp = (mode_of(d) == 1) || ((mode_of(d) == 2) && mi);
    for (int i = 0; i < lanes_of(d); i++)
      r[i*8 +: 8] = byp ? e[i*8 +: 8] : (s[i] ? c[i*8 +: 8] : dd[i*8 +: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", name, act, exp, dsel, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic o, input logic mi,
                      input logic [3:0] s, input logic [31:0] c, input logic [31:0] d,
                      input logic [31:0] e);
    logic exp_ov, exp_ir, tr, acc;
    logic [31:0] res;
    rst = r; iv = v; orr = o; mode_i = mi; sel_v = s; c_v = c; d_v = d; e_v = e;
    #1;
    exp_ov = (q.size() > 0) && ((ecnt - q[0].acc) >= stages_of(dsel) - 1);
    exp_ir = (q.size() < stages_of(dsel)) || o;
    s_ov = ov; s_od = od; s_ir = ir; s_xc = xc;
    if (armed) begin
      chk("out_valid", {31'b0, ov}, {31'b0, exp_ov});
      chk("in_ready", {31'b0, ir}, {31'b0, exp_ir});
      chk("xfer_count", {16'b0, xc}, mcount & cmask_of(dsel));
      if (exp_ov) chk("out_data", od, q[0].data);
    end
    res = model_res(dsel, mi, s, c, d, e);
    tr  = exp_ov && o;
    acc = v && exp_ir;
    @(posedge clk);
    if (r) begin
      q.delete();
      mcount = 0;
      ecnt   = 0;
      armed  = 1;
    end else if (armed) begin
      ecnt++;
      if (tr) begin
        void'(q.pop_front());
        mcount++;
      end
      if (acc) q.push_back('{res, ecnt});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic mi);
    step(1'b0, 1'b0, 1'b1, mi, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic start(input int which);
    dsel  = which;
    armed = 0;
    q.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    idle(1'b0);
    chk("reset_out_valid", {31'b0, s_ov}, 32'd0);
    chk("reset_out_data", s_od, 32'd0);
    chk("reset_in_ready", {31'b0, s_ir}, 32'd1);
    chk("reset_xfer_count", {16'b0, s_xc}, 32'd0);
  endtask

  task automatic random_run(input int n, input bit with_rst);
    for (int t = 0; t < n; t++)
      step(with_rst && ($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
           $urandom, $urandom, $urandom);
    for (int t = 0; t < 4; t++) idle(1'b0);
    chk("drained", {31'b0, s_ov}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nv;
    logic [7:0] bv;
    logic [31:0] lit [3];
    total = 0; bad = 0; ecnt = 0; mcount = 0; armed = 0; dsel = 1;
    rst = 1'b1; iv = 1'b0; orr = 1'b1; mode_i = 1'b0; sel_v = '0;
    c_v = '0; d_v = '0; e_v = '0;
    @(negedge clk);

    // Select mode (MODE=0, mode_i high must be ignored), 2-cycle latency.
    start(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, 32'h44332211, 32'hA4A3A2A1, 32'h5E5E5E5E);
    chk("sel_accept", {31'b0, s_ir}, 32'd1);
    idle(1'b1);
    chk("sel_latency_early", {31'b0, s_ov}, 32'd0);
    idle(1'b1);
    chk("sel_latency_valid", {31'b0, s_ov}, 32'd1);
    chk("sel_data", s_od, 32'hA433A211);
    idle(1'b1);
    chk("sel_count", {16'b0, s_xc}, 32'd1);

    // Counter wrap with CNT_W=4: 17 transfers leave 1.
    start(1);
    for (int t = 0; t < 19; t++)
      step(1'b0, t < 17, 1'b1, 1'b1, 4'($urandom), $urandom, $urandom, $urandom);
    idle(1'b0);
    chk("wrap_count", {16'b0, s_xc}, 32'd1);
    random_run(200, 1'b0);

    // Runtime bypass on the 4-lane pipe: sel ignored.
    start(0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h44332211, 32'hA4A3A2A1, 32'h5E5E5E5E);
    idle(1'b0);
    idle(1'b0);
    chk("bypass_data", s_od, 32'h5E5E5E5E);

    // Per-beat mode capture: modes 0,1,0 back to back.
    start(0);
    lit[0] = 32'hA433A211; lit[1] = 32'h5E5E5E5E; lit[2] = 32'hA433A211;
    for (int t = 0; t < 6; t++) begin
      step(1'b0, t < 3, 1'b1, t == 1, 4'b0101, 32'h44332211, 32'hA4A3A2A1, 32'h5E5E5E5E);
      if (t >= 2 && t <= 4) begin
        chk("mode_seq_valid", {31'b0, s_ov}, 32'd1);
        chk("mode_seq_data", s_od, lit[t-2]);
      end
    end
    chk("mode_seq_end", {31'b0, s_ov}, 32'd0);

    // Backpressure: 5 beats with consumer stalled, then released.
    start(0);
    k = 0;
    for (int t = 0; t < 4; t++) begin
      bv = 8'(16 + k);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, {4{bv}}, 32'h0, 32'h0);
      if (s_ir) k++;
      if (t == 3) chk("bp_hold", s_od, 32'h10101010);
    end
    chk("bp_accepts", k, 32'd2);
    chk("bp_in_ready_low", {31'b0, s_ir}, 32'd0);
    nv = 0;
    for (int t = 0; t < 8; t++) begin
      bv = 8'(16 + k);
      step(1'b0, k < 5, 1'b1, 1'b0, 4'hF, {4{bv}}, 32'h0, 32'h0);
      if (k < 5 && s_ir) k++;
      if (t < 5 && s_ov) nv++;
    end
    chk("bp_no_gaps", nv, 32'd5);
    chk("bp_count", {16'b0, s_xc}, 32'd5);

    // Reset with two beats in flight; in_valid during reset is not taken.
    start(0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h77777777, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h78787878, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h79797979, 32'h0, 32'h0);
    idle(1'b0);
    chk("midrst_valid", {31'b0, s_ov}, 32'd0);
    chk("midrst_count", {16'b0, s_xc}, 32'd0);
    for (int t = 0; t < 4; t++) begin
      idle(1'b0);
      chk("midrst_no_ghost", {31'b0, s_ov}, 32'd0);
    end
    random_run(400, 1'b1);

    // Single-lane, single-stage fixed bypass.
    start(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h11, 32'h22, 32'hC3);
    idle(1'b0);
    chk("s1_valid", {31'b0, s_ov}, 32'd1);
    chk("s1_data", s_od, 32'h000000C3);
    random_run(300, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_select_pipe.md
Name: cond_select_pipe

Overview:
Parametrised, multi-channel successor to a single conditional-select always_comb block. Per channel it computes b = sel ? c : d, or b = e when bypassed. Mode is chosen by parameter or at runtime, not by preprocessor directives. Results go through a STAGES-deep valid/ready pipeline with backpressure and a transfer counter. It sits between a producer and consumer on a streaming datapath.

Parameters:
WIDTH, 8, data bits per channel (>=1)
CHANNELS, 4, number of independent lanes (>=1)
STAGES, 2, pipeline register stages (>=1)
MODE, 0, 0 = conditional select, 1 = bypass (b = e), 2 = runtime select via mode_i
CNT_W, 16, width of xfer_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mode_i  in  1  runtime mode when MODE==2 (0 select, 1 bypass); ignored otherwise
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
sel  in  CHANNELS  per-lane select, bit i for lane i
c_data  in  CHANNELS*WIDTH  lane i at [i*WIDTH +: WIDTH], chosen when sel[i]=1
d_data  in  CHANNELS*WIDTH  chosen when sel[i]=0
e_data  in  CHANNELS*WIDTH  chosen in bypass mode
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_data  out  CHANNELS*WIDTH  selected result, same lane packing
xfer_count  out  CNT_W  completed output handshakes, modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at rising edge): all stage valids=0, all stage data=0, xfer_count=0.
- Outputs after reset: out_valid=0, out_data=0, in_ready=1. in_ready is combinational and is 1 while rst is held after the first reset edge.
- Effective mode: MODE 0 means select, MODE 1 means bypass, MODE 2 uses mode_i sampled with the input beat. The mode is captured per beat, so changing mode_i mid-stream affects only later beats.
- Select lane i: result_i = sel[i] ? c_i : d_i.
- Bypass lane i: result_i = e_i, and sel is ignored.
- The function is evaluated combinationally on the inputs and written into stage 0 on acceptance. No arithmetic is performed; widths are preserved exactly.
- Input accept: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- Pipeline: stage k holds {valid_k, data_k}, and stage STAGES-1 drives out_valid and out_data.
- Stage advance rule: stage k loads from stage k-1 (stage 0 from the input) when !valid_k, or when stage k is emptying this cycle. The last stage empties on an output transfer; stage k empties when stage k+1 loads.
- Bubbles collapse: an empty stage always loads regardless of downstream stall.
- in_ready = !valid_0 || stage 0 advancing. The chain is combinational from out_ready.
- Latency: accepted beat appears on out_valid exactly STAGES cycles later if there are no stalls. Throughput is 1 beat/cycle.
- Full: all STAGES valid and out_ready=0 gives in_ready=0, with no data loss or duplication. out_data is held stable while out_valid && !out_ready.
- Empty: out_valid=0. out_data holds the last transferred value and is don't-care for checking.
- Simultaneous accept and transfer on a full pipe: both occur and occupancy is unchanged.
- Ordering is strictly FIFO, with no reordering across lanes or beats.
- xfer_count increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: in-flight beats are discarded, none appear after reset, and xfer_count returns to 0.
- in_valid during reset is not accepted.

Test Plan:
- WIDTH=8, CHANNELS=4, STAGES=2, MODE=0: sel=4'b0101, c lanes={0x11,0x22,0x33,0x44}, d lanes={0xA1,0xA2,0xA3,0xA4}, out_ready=1 -> out_data lanes {0x11,0xA2,0x33,0xA4}, out_valid exactly 2 cycles after accept, xfer_count=1.
- MODE=1: e lanes={0x5E,0x5E,0x5E,0x5E}, sel=4'b1111 -> output is the e lanes, sel ignored.
- MODE=2: back-to-back beats with mode_i=0, then 1, then 0 -> each output reflects the mode of its own beat, in order, and 3 consecutive out_valid cycles.
- Backpressure: 5 beats streamed with out_ready=0 -> in_ready drops after 2 accepts and out_data is held. Raise out_ready -> all 5 emerge in order with no gaps, and xfer_count=5.
- Reset mid-stream: 2 beats in flight, pulse rst one cycle -> out_valid=0 and xfer_count=0 next cycle, and neither beat ever appears.
- CNT_W=4: 17 transfers -> xfer_count wraps to 1. Also run STAGES=1, CHANNELS=1 with a random valid/ready scoreboard and compare against the reference model.
